// File: rtl/serial_alu_ctrl.sv
// Bit-serial ADD/SUB/INC/DEC unit: one result bit per cycle, LSB first, through a
// single full-adder cell and a 1-bit carry register. Handshake: start is accepted only in IDLE.

module FA2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_sum;
  logic             w_co;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;

  FA2 u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  // SUB and INC become additions with carry-in 1 (a + ~b + 1, a + 0 + 1).
  always_comb begin
    w_b_load = b;
    case (op)
      2'b00:   w_b_load = b;
      2'b01:   w_b_load = ~b;
      2'b10:   w_b_load = '0;
      default: w_b_load = '1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_res   <= '0;
      r_carry <= op[0] ^ op[1];
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // On the MSB step r_carry is the carry into the MSB.
        r_y    <= w_res_next;
        r_cout <= w_co;
        r_ovf  <= r_carry ^ w_co;
        r_zero <= (w_res_next == '0);
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign y         = r_y;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal values 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 ADD (a+b), 01 SUB (a-b), 10 INC (a+1), 11 DEC (a-1).
REQ-006 a  input  WIDTH  first operand; captured on start acceptance.
REQ-007 b  input  WIDTH  second operand; captured on start acceptance; ignored for INC and DEC.
REQ-008 busy  output  1  high while the serial computation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the cycle in which the result first becomes valid.
REQ-010 y  output  WIDTH  result register.
REQ-011 cout  output  1  carry out of the MSB (for SUB and DEC: 1 = no borrow).
REQ-012 ovf  output  1  two's-complement overflow flag.
REQ-013 zero  output  1  high when y is all zeros.

Function
REQ-014 The block shall compute one result bit per cycle, LSB first, through a single instance of the codebase full-adder cell FA2 and a 1-bit carry register; no parallel adder is permitted.
REQ-015 The FSM states shall be IDLE, RUN and DONE.
REQ-016 FSM transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after exactly WIDTH RUN cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 Start acceptance (IDLE with start=1) shall capture into internal shift registers:
- a unchanged.
- B operand: b for ADD; ~b for SUB; all-zeros for INC; all-ones for DEC.
- Carry register: 0 for ADD and DEC; 1 for SUB and INC.
REQ-018 Each RUN cycle shall:
- Feed the current LSBs of A and B plus the carry register into FA2.
- Shift the sum bit into the result shift register from the MSB side.
- Update the carry register.
- Shift A and B right by one.
- Increment a bit counter.
REQ-019 The bit counter shall be wide enough to hold WIDTH and shall not wrap during RUN.
REQ-020 On the RUN -> DONE edge the block shall load y, cout, ovf and zero:
- y: the completed result register.
- cout: the final carry register value.
- ovf: the carry into the MSB XOR the carry out of the MSB.
- zero: high when the completed result is all zeros.
REQ-021 Latency: if start is accepted at rising edge k, busy shall be 1 in cycles k+1..k+WIDTH, and done and the new y/flags shall appear in cycle k+WIDTH+1.
REQ-022 done shall be 1 only in DONE; busy shall be 1 only in RUN.
REQ-023 y, cout, ovf and zero shall hold their values from the DONE load until the next DONE load.
REQ-024 start in RUN or DONE shall be ignored, with no effect on state or outputs; the earliest next acceptance is the first IDLE cycle after DONE.
REQ-025 Changes on a, b or op after start acceptance shall not affect the operation in progress.
REQ-026 Arithmetic shall be modulo 2^WIDTH; y shall carry no extra bits.

Reset
REQ-027 While rst_n=0, independent of clk, the block shall:
- Force the FSM to IDLE.
- Clear busy, done, y, cout, ovf, all shift registers, the carry register and the bit counter.
- Set zero to 1, since y=0.
REQ-028 Reset asserted during RUN or DONE shall abort the operation with no done pulse; the first start accepted after rst_n rises shall proceed normally.

Verification
REQ-029 With WIDTH=8, the bench shall cover these six scenarios:
- ADD a=0x7F, b=0x01 -> y=0x80, cout=0, ovf=1, zero=0; done exactly 9 cycles after the accepting edge, busy high for 8 cycles.
- SUB a=0x05, b=0x05 -> y=0x00, cout=1, ovf=0, zero=1.
- INC a=0xFF -> y=0x00, cout=1, ovf=0, zero=1; then DEC a=0x80 -> y=0x7F, cout=1, ovf=1, zero=0.
- ADD a=0x12, b=0x34 with start held high and a, b, op changed every cycle during RUN -> y=0x46, exactly one done pulse; the next operation is accepted only in the IDLE cycle after DONE.
- rst_n pulled low for 1 cycle during the 4th RUN cycle of an ADD -> busy=0, done=0, y=0x00, zero=1 immediately; no done pulse follows; a subsequent SUB a=0x00, b=0x01 -> y=0xFF, cout=0, ovf=0.
- Random regression of 1000 operations across all four op codes -> y, cout and ovf match a golden 8-bit reference model, and y holds its value between done pulses.
